// File: rtl/des_round_sequencer_if.sv
// Handshake and key-schedule control bundle between the triple-DES sequencer,
// the block buffer and the cipher core.
interface des_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       decrypt;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic       load_en;
  logic       round_en;
  logic [4:0] round_count;
  logic [1:0] key_count;
  logic       cnt_rollover;
  logic       key_rollover;
  logic       reverse;

  modport master (
    input  in_valid, decrypt, abort, out_ready,
    output in_ready, out_valid, load_en, round_en,
           round_count, key_count, cnt_rollover, key_rollover, reverse
  );

  modport slave (
    output in_valid, decrypt, abort, out_ready,
    input  in_ready, out_valid, load_en, round_en,
           round_count, key_count, cnt_rollover, key_rollover, reverse
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Triple-DES round sequencer: per block, NUM_PASSES passes of one load cycle plus
// NUM_ROUNDS Feistel rounds, with EDE/DED subkey ordering for the key generator.
module des_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned NUM_PASSES = 3
) (
  input  logic               clk,
  input  logic               rst,
  des_round_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_RC = 5'(NUM_ROUNDS);
  localparam logic [1:0] LAST_KC = 2'(NUM_PASSES - 1);

  state_t state;
  logic   decrypt_l;
  logic   cnt_roll_r;
  logic   key_roll_r;
  logic   busy;

  assign busy = (state == LOAD) || (state == ROUND);

  // An abort must flush the key schedule in the same cycle it is seen, so the
  // abort contribution to key_rollover bypasses the output registers.
  assign bus.key_rollover = key_roll_r | (bus.abort & busy & ~rst);
  assign bus.cnt_rollover = cnt_roll_r & ~(bus.abort & busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      decrypt_l       <= 1'b0;
      bus.round_count <= '0;
      bus.key_count   <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.load_en     <= 1'b0;
      bus.round_en    <= 1'b0;
      bus.reverse     <= 1'b0;
      cnt_roll_r      <= 1'b0;
      key_roll_r      <= 1'b0;
    end else begin
      bus.load_en  <= 1'b0;
      bus.round_en <= 1'b0;
      cnt_roll_r   <= 1'b0;
      key_roll_r   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state           <= LOAD;
            decrypt_l       <= bus.decrypt;
            bus.in_ready    <= 1'b0;
            bus.load_en     <= 1'b1;
            bus.round_count <= '0;
            bus.key_count   <= '0;
            bus.reverse     <= bus.decrypt;
          end
        end

        LOAD, ROUND: begin
          if (bus.abort) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b1;
            bus.round_count <= '0;
            bus.key_count   <= '0;
            bus.reverse     <= 1'b0;
          end else if ((state == LOAD) || (bus.round_count != LAST_RC)) begin
            state           <= ROUND;
            bus.round_en    <= 1'b1;
            bus.round_count <= bus.round_count + 5'd1;
            if ((bus.round_count + 5'd1) == LAST_RC) begin
              cnt_roll_r <= (bus.key_count != LAST_KC);
              key_roll_r <= (bus.key_count == LAST_KC);
            end
          end else if (bus.key_count != LAST_KC) begin
            state           <= LOAD;
            bus.load_en     <= 1'b1;
            bus.round_count <= '0;
            bus.key_count   <= bus.key_count + 2'd1;
            // The middle pass (index 1) runs in the opposite direction.
            bus.reverse     <= decrypt_l ^ (bus.key_count == 2'd0);
          end else begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.round_count <= '0;
            bus.key_count   <= '0;
            bus.reverse     <= 1'b0;
          end
        end

        DONE: begin
          if (bus.abort || bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed self-checking bench for des_round_sequencer: encrypt/decrypt passes,
// backpressure, abort, mid-block reset and back-to-back blocks.
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  des_round_sequencer_if b ();

  des_round_sequencer #(.NUM_ROUNDS(16), .NUM_PASSES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] CR_EXP = {18'd0, 5'd16, 2'd0, 5'd16, 2'd1};
  localparam logic [31:0] KR_EXP = {25'd0, 5'd16, 2'd2};
  localparam logic [13:0] RST_OUTS = {1'b1, 13'd0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_load, n_round, n_viol, n_ov, n_acc, acc_cyc, ov_cyc;
  int acc_t[4];
  logic [31:0] cr_log, kr_log;
  logic [15:0] rev_log;
  logic ov_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {b.in_ready, b.out_valid, b.load_en, b.round_en, b.cnt_rollover,
            b.key_rollover, b.reverse, b.round_count, b.key_count};
  endfunction

  task automatic clear_logs();
    n_load = 0; n_round = 0; n_viol = 0; n_ov = 0; n_acc = 0;
    acc_cyc = 0; ov_cyc = 0; cr_log = '0; kr_log = '0; rev_log = '0;
    for (int i = 0; i < 4; i++) acc_t[i] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (b.load_en) begin
      n_load++;
      rev_log = {rev_log[14:0], b.reverse};
      if (b.key_count == 2'd0) begin
        acc_cyc = cyc;
        if (n_acc < 4) acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    if (b.round_en) n_round++;
    if (b.cnt_rollover) cr_log = {cr_log[24:0], b.round_count, b.key_count};
    if (b.key_rollover) kr_log = {kr_log[24:0], b.round_count, b.key_count};
    if (b.round_count > 5'd16 || b.key_count > 2'd2 || (b.cnt_rollover && b.key_rollover))
      n_viol++;
    if (b.out_valid && !ov_prev) begin
      ov_cyc = cyc;
      n_ov++;
    end
    ov_prev = b.out_valid;
  endtask

  task automatic start_block(input logic dec);
    clear_logs();
    b.in_valid = 1'b1;
    b.decrypt  = dec;
    step();
    b.in_valid = 1'b0;
    b.decrypt  = ~dec;
    check_eq("accept_load", {31'd0, b.load_en}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!b.out_valid && n < 200) begin
      step();
      n++;
    end
    check_eq({tag, "_latency"}, ov_cyc - acc_cyc, 32'd51);
  endtask

  task automatic finish_block(input string tag, input logic dec);
    step();
    check_eq({tag, "_idle"}, {30'd0, b.in_ready, b.out_valid}, 32'd2);
    check_eq({tag, "_loads"}, n_load, 32'd3);
    check_eq({tag, "_rounds"}, n_round, 32'd48);
    check_eq({tag, "_cnt_roll"}, cr_log, CR_EXP);
    check_eq({tag, "_key_roll"}, kr_log, KR_EXP);
    check_eq({tag, "_reverse"}, {16'd0, rev_log}, dec ? 32'h5 : 32'h2);
    check_eq({tag, "_invariants"}, n_viol, 32'd0);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    b.in_valid = 1'b0; b.decrypt = 1'b0; b.abort = 1'b0; b.out_ready = 1'b1;
    clear_logs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check_eq("reset_outs", {18'd0, outs()}, {18'd0, RST_OUTS});

    // T1 encrypt, T2 decrypt
    start_block(1'b0); wait_done("enc"); finish_block("enc", 1'b0);
    start_block(1'b1); wait_done("dec"); finish_block("dec", 1'b1);

    // T3 backpressure
    b.out_ready = 1'b0;
    start_block(1'b0); wait_done("bp");
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_hold", {24'd0, b.out_valid, b.in_ready, b.round_count, b.key_count},
               {24'd0, 1'b1, 1'b0, 5'd0, 2'd0});
    end
    b.out_ready = 1'b1;
    finish_block("bp", 1'b0);

    // T4 abort mid-block at kc=1, rc=7
    start_block(1'b0);
    for (int i = 0; i < 100 && !(b.key_count == 2'd1 && b.round_count == 5'd7); i++) step();
    b.abort = 1'b1;
    #1;
    check_eq("abort_pulse", {31'd0, b.key_rollover}, 32'd1);
    check_eq("abort_no_cnt", {31'd0, b.cnt_rollover}, 32'd0);
    step();
    b.abort = 1'b0;
    check_eq("abort_idle_outs", {18'd0, outs()}, {18'd0, RST_OUTS});
    check_eq("abort_no_ov", n_ov, 32'd0);
    start_block(1'b0); wait_done("post_abort"); finish_block("post_abort", 1'b0);

    // abort with in_valid in IDLE: accepted; abort then seen in LOAD
    b.in_valid = 1'b1; b.abort = 1'b1;
    #1;
    check_eq("abort_idle_nopulse", {31'd0, b.key_rollover}, 32'd0);
    step();
    b.in_valid = 1'b0;
    #1;
    check_eq("abort_idle_accept", {31'd0, b.load_en}, 32'd1);
    check_eq("abort_load_pulse", {31'd0, b.key_rollover}, 32'd1);
    step();
    b.abort = 1'b0;
    check_eq("abort_load_idle", {31'd0, b.in_ready}, 32'd1);

    // abort in DONE drops out_valid without a pulse
    b.out_ready = 1'b0;
    start_block(1'b1); wait_done("abort_done");
    b.abort = 1'b1;
    #1;
    check_eq("abort_done_nopulse", {31'd0, b.key_rollover}, 32'd0);
    step();
    b.abort = 1'b0; b.out_ready = 1'b1;
    check_eq("abort_done_idle", {30'd0, b.in_ready, b.out_valid}, 32'd2);

    // T5 reset at kc=2, rc=12 with in_valid held through reset
    start_block(1'b0);
    b.in_valid = 1'b1;
    for (int i = 0; i < 100 && !(b.key_count == 2'd2 && b.round_count == 5'd12); i++) step();
    rst = 1'b1;
    step();
    check_eq("rst_mid_outs", {18'd0, outs()}, {18'd0, RST_OUTS});
    step();
    check_eq("rst_hold_outs", {18'd0, outs()}, {18'd0, RST_OUTS});
    clear_logs();
    b.decrypt = 1'b1;
    rst = 1'b0;
    step();
    b.in_valid = 1'b0; b.decrypt = 1'b0;
    check_eq("post_rst_accept", {31'd0, b.load_en}, 32'd1);
    wait_done("post_rst"); finish_block("post_rst", 1'b1);

    // T6 back-to-back, alternating mode per block
    clear_logs();
    b.out_ready = 1'b1; b.in_valid = 1'b1; b.decrypt = 1'b0;
    for (int i = 0; i < 400 && n_ov < 4; i++) begin
      step();
      if (b.load_en && b.key_count == 2'd0) b.decrypt = ~b.decrypt;
      if (n_acc == 4) b.in_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) check_eq("b2b_spacing", acc_t[i+1] - acc_t[i], 32'd53);
    check_eq("b2b_blocks", n_ov, 32'd4);
    check_eq("b2b_loads", n_load, 32'd12);
    check_eq("b2b_rounds", n_round, 32'd192);
    check_eq("b2b_reverse", {16'd0, rev_log}, 32'h0555);
    check_eq("b2b_invariants", n_viol, 32'd0);
    step();
    check_eq("b2b_idle", {30'd0, b.in_ready, b.out_valid}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
